measure_sequencer: RTL
======================

// Module: measure_sequencer
// PURPOSE
//   Downstream of the command decoder. Consumes FreqMode/StartMeasure and runs one measurement:
//   holds the DDS frequency select, waits for analog settling, then captures NUM_SAMPLES ADC
//   beats on the voltage and current channels. Reports peak-to-peak amplitude of each channel
//   to the impedance calculation stage.
// PARAMETERS
//   ADC_W        12    ADC sample width, unsigned offset-binary
//   SETTLE_CYC   1000  ExtClk cycles spent in SETTLE after a start, >=1
//   NUM_SAMPLES  1024  AdcValid beats captured per measurement, >=1
// PORTS
//   ExtClk       in   1      system clock; single clock domain
//   ExtReset     in   1      synchronous, active-high reset
//   FreqMode     in   2      frequency selection from command decoder
//   StartMeasure in   1      one-cycle start pulse from command decoder
//   AdcV         in   ADC_W  voltage-channel sample
//   AdcI         in   ADC_W  current-channel sample
//   AdcValid     in   1      AdcV/AdcI valid this cycle; no backpressure
//   DdsFreqSel   out  2      frequency select to DDS
//   Busy         out  1      high in SETTLE, CAPTURE and REPORT
//   VppOut       out  ADC_W  voltage peak-to-peak, maxV-minV
//   IppOut       out  ADC_W  current peak-to-peak, maxI-minI
//   ResultValid  out  1      one-cycle pulse when VppOut/IppOut are updated
// BEHAVIOUR
//   Reset: state=IDLE.
//     - DdsFreqSel=0, Busy=0, VppOut=0, IppOut=0, ResultValid=0.
//     - All counters=0, minV/minI=all-ones, maxV/maxI=0.
//   IDLE:
//     - DdsFreqSel <= FreqMode every cycle, so a frequency change reaches the DDS 1 cycle later.
//     - StartMeasure=1: go to SETTLE next cycle. Busy=1 from that cycle.
//     - Clear the settle counter and load min/max init values.
//     - DdsFreqSel is frozen at the value it holds on that edge.
//   SETTLE:
//     - Count ExtClk cycles. Go to CAPTURE after exactly SETTLE_CYC cycles in SETTLE.
//     - AdcValid is ignored.
//   CAPTURE:
//     - On each AdcValid=1: update maxV/minV/maxI/minI with unsigned compare and increment
//       the sample counter.
//     - On the beat that makes the count equal NUM_SAMPLES, go to REPORT. That beat is
//       included in the statistics.
//     - AdcValid=0 cycles do not count. There is no timeout.
//   REPORT, one cycle:
//     - VppOut <= maxV-minV, IppOut <= maxI-minI (never negative, since max>=min).
//     - ResultValid=1 in the cycle after REPORT, then IDLE with Busy=0.
//     - VppOut/IppOut hold until the next REPORT.
//   Counter widths: $clog2(SETTLE_CYC+1) and $clog2(NUM_SAMPLES+1). No wrap inside a run.
//   Simultaneous/illegal events:
//     - StartMeasure while Busy=1: ignored, no restart, no queueing.
//     - FreqMode change while Busy=1: ignored until IDLE, then tracked.
//     - StartMeasure in the same cycle REPORT exits: ignored.
//     - ExtReset mid-run: immediate return to reset values, partial results discarded,
//       ResultValid stays 0.
//   Constant input across the capture window gives Vpp=0 (min==max).
// TESTING  (bench: SETTLE_CYC=8, NUM_SAMPLES=4)
//   1. Reset, then FreqMode=2 -> DdsFreqSel=2 one cycle later. Busy=0, outputs 0.
//   2. Start pulse; AdcV={100,900,400,500}, AdcI={10,20,30,40} on valid beats after settle
//      -> VppOut=800, IppOut=30, single ResultValid pulse, then Busy=0.
//   3. AdcValid=1 held during SETTLE with AdcV=4095 -> ignored. Capture of constant 2048
//      -> VppOut=0.
//   4. FreqMode 1->3 and a second StartMeasure mid-CAPTURE -> DdsFreqSel stays 1, exactly one
//      ResultValid. After IDLE, DdsFreqSel=3.
//   5. ExtReset after 2 of 4 beats -> all outputs 0, no ResultValid. A new start gives
//      correct results from fresh samples only.
//   6. AdcValid gaps (1 valid per 3 cycles) -> exactly 4 beats counted. ResultValid
//      1 cycle after the 4th beat plus the REPORT cycle.

Source files
------------

// File: rtl/measure_sequencer.sv
// Measurement sequencer: holds DDS select, settles, captures ADC beats,
// and reports peak-to-peak amplitude of the voltage and current channels.
module measure_sequencer #(
  parameter int ADC_W       = 12,
  parameter int SETTLE_CYC  = 1000,
  parameter int NUM_SAMPLES = 1024
) (
  input  logic             ExtClk,
  input  logic             ExtReset,
  input  logic [1:0]       FreqMode,
  input  logic             StartMeasure,
  input  logic [ADC_W-1:0] AdcV,
  input  logic [ADC_W-1:0] AdcI,
  input  logic             AdcValid,
  output logic [1:0]       DdsFreqSel,
  output logic             Busy,
  output logic [ADC_W-1:0] VppOut,
  output logic [ADC_W-1:0] IppOut,
  output logic             ResultValid
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int NW = $clog2(NUM_SAMPLES + 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYC - 1);
  localparam logic [NW-1:0] NLAST = NW'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_REPORT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SW-1:0]    r_scnt;
  logic [NW-1:0]    r_ncnt;
  logic [ADC_W-1:0] r_maxv;
  logic [ADC_W-1:0] r_minv;
  logic [ADC_W-1:0] r_maxi;
  logic [ADC_W-1:0] r_mini;
  logic [ADC_W-1:0] r_vpp;
  logic [ADC_W-1:0] r_ipp;
  logic [1:0]       r_freq;
  logic             r_rv;

  always_ff @(posedge ExtClk) begin
    if (ExtReset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (StartMeasure) w_next = S_SETTLE;
      S_SETTLE:  if (r_scnt == SLAST) w_next = S_CAPTURE;
      S_CAPTURE: if (AdcValid && r_ncnt == NLAST) w_next = S_REPORT;
      S_REPORT:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Frequency select is only tracked while idle; a start freezes it.
  always_ff @(posedge ExtClk) begin
    if (ExtReset) begin
      r_scnt <= '0;
      r_ncnt <= '0;
      r_maxv <= '0;
      r_minv <= '1;
      r_maxi <= '0;
      r_mini <= '1;
      r_vpp  <= '0;
      r_ipp  <= '0;
      r_freq <= '0;
      r_rv   <= 1'b0;
    end else begin
      r_rv <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (StartMeasure) begin
            r_scnt <= '0;
            r_ncnt <= '0;
            r_maxv <= '0;
            r_minv <= '1;
            r_maxi <= '0;
            r_mini <= '1;
          end else begin
            r_freq <= FreqMode;
          end
        end
        S_SETTLE: r_scnt <= r_scnt + SW'(1);
        S_CAPTURE: begin
          if (AdcValid) begin
            if (AdcV > r_maxv) r_maxv <= AdcV;
            if (AdcV < r_minv) r_minv <= AdcV;
            if (AdcI > r_maxi) r_maxi <= AdcI;
            if (AdcI < r_mini) r_mini <= AdcI;
            r_ncnt <= r_ncnt + NW'(1);
          end
        end
        S_REPORT: begin
          r_vpp <= r_maxv - r_minv;
          r_ipp <= r_maxi - r_mini;
          r_rv  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign DdsFreqSel  = r_freq;
  assign Busy        = (r_state != S_IDLE);
  assign VppOut      = r_vpp;
  assign IppOut      = r_ipp;
  assign ResultValid = r_rv;

endmodule
